// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer
//   Walks a table of NUM_REGS 24-bit words {slave_addr, reg_addr, data} and
//   writes each one to the codec through i2c_controller. Each write is checked
//   for ACK. A NACK or a timeout causes a retry, up to MAX_RETRIES extra
//   attempts per entry. Completion or failure is reported to the audio subsystem.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   restart         1-cycle pulse, re-runs the table from entry 0 (DONE/FAIL only)
//   cfg_addr        table index being requested
//   cfg_data        table word for cfg_addr (combinational lookup)
//   transfer_start  level to i2c_controller, high for the whole frame
//   transfer_data   registered frame, stable while transfer_start=1
//   transfer_end    controller finished the frame (level)
//   transfer_ack_n  sticky NACK from the controller, valid with transfer_end
//   cfg_busy        sequence in progress
//   cfg_done        all entries ACKed (level)
//   cfg_error       an entry exhausted its retries (level)
//   err_index       index of the failing entry
//
// Optional feature (macro CODEC_CFG_USER_WRITE_EN)
//   Adds usr_req/usr_data/usr_ack/usr_nack. These allow a single write to be
//   issued from DONE. The write has no retries and returns to DONE.
module codec_config_sequencer #(
    parameter int NUM_REGS       = 11,
    parameter int MAX_RETRIES    = 3,
    parameter int STARTUP_CYCLES = 1_000_000,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    output logic [7:0]  cfg_addr,
    input  logic [23:0] cfg_data,
    output logic        transfer_start,
    output logic [23:0] transfer_data,
    input  logic        transfer_end,
    input  logic        transfer_ack_n,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [7:0]  err_index
`ifdef CODEC_CFG_USER_WRITE_EN
    ,
    input  logic        usr_req,
    input  logic [23:0] usr_data,
    output logic        usr_ack,
    output logic        usr_nack
`endif
);

    localparam int CNT_MAX0 = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > GAP_CYCLES) ? CNT_MAX0 : GAP_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_STARTUP, ST_GAP, ST_LOAD, ST_XFER, ST_CHECK, ST_DONE, ST_FAIL
    } state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        retry_cnt;
    logic              nack_q;
`ifdef CODEC_CFG_USER_WRITE_EN
    logic              usr_mode;
`endif

    // The controller sees start high only in XFER and CHECK. Because this is a
    // pure decode of the async-reset state register, rst drops it immediately.
    assign transfer_start = (state == ST_XFER) || (state == ST_CHECK);

    always_comb begin
        next_state = state;
        case (state)
            ST_STARTUP: if (cnt == CNT_W'(STARTUP_CYCLES - 1)) next_state = ST_GAP;
            ST_GAP:     if (cnt == CNT_W'(GAP_CYCLES - 1))     next_state = ST_LOAD;
            ST_LOAD:    next_state = ST_XFER;
            ST_XFER:    if (transfer_end || cnt == CNT_W'(TIMEOUT_CYCLES - 1)) next_state = ST_CHECK;
            ST_CHECK: begin
`ifdef CODEC_CFG_USER_WRITE_EN
                if (usr_mode)
                    next_state = ST_DONE;
                else
`endif
                if (!nack_q)
                    next_state = (int'(cfg_addr) == NUM_REGS - 1) ? ST_DONE : ST_GAP;
                else if (int'(retry_cnt) < MAX_RETRIES)
                    next_state = ST_GAP;
                else
                    next_state = ST_FAIL;
            end
            ST_DONE: begin
                if (restart)
                    next_state = ST_GAP;
`ifdef CODEC_CFG_USER_WRITE_EN
                else if (usr_req)
                    next_state = ST_GAP;
`endif
            end
            ST_FAIL:    if (restart) next_state = ST_GAP;
            default:    next_state = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_STARTUP;
            cnt           <= '0;
            retry_cnt     <= '0;
            nack_q        <= 1'b0;
            cfg_addr      <= '0;
            err_index     <= '0;
            transfer_data <= '0;
            cfg_busy      <= 1'b1;
            cfg_done      <= 1'b0;
            cfg_error     <= 1'b0;
`ifdef CODEC_CFG_USER_WRITE_EN
            usr_mode      <= 1'b0;
            usr_ack       <= 1'b0;
            usr_nack      <= 1'b0;
`endif
        end else begin
            state <= next_state;
            // One shared counter serves startup, gap and timeout. It restarts on every state change.
            cnt   <= (next_state != state) ? '0 : cnt + 1'b1;
`ifdef CODEC_CFG_USER_WRITE_EN
            usr_ack  <= 1'b0;
            usr_nack <= 1'b0;
`endif
            case (state)
                ST_LOAD: begin
`ifdef CODEC_CFG_USER_WRITE_EN
                    if (!usr_mode)
`endif
                    transfer_data <= cfg_data;
                end
                ST_XFER: begin
                    // Leaving without transfer_end means timeout, so it is treated as a NACK.
                    if (next_state == ST_CHECK)
                        nack_q <= transfer_ack_n | ~transfer_end;
                end
                ST_CHECK: begin
`ifdef CODEC_CFG_USER_WRITE_EN
                    if (usr_mode) begin
                        usr_mode <= 1'b0;
                        usr_ack  <= ~nack_q;
                        usr_nack <= nack_q;
                    end else
`endif
                    if (!nack_q) begin
                        retry_cnt <= '0;
                        if (int'(cfg_addr) == NUM_REGS - 1) begin
                            cfg_done <= 1'b1;
                            cfg_busy <= 1'b0;
                        end else begin
                            cfg_addr <= cfg_addr + 8'd1;
                        end
                    end else if (int'(retry_cnt) < MAX_RETRIES) begin
                        retry_cnt <= retry_cnt + 4'd1;
                    end else begin
                        err_index <= cfg_addr;
                        cfg_error <= 1'b1;
                        cfg_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        cfg_done  <= 1'b0;
                        cfg_addr  <= '0;
                        retry_cnt <= '0;
                        cfg_busy  <= 1'b1;
                    end
`ifdef CODEC_CFG_USER_WRITE_EN
                    else if (usr_req) begin
                        usr_mode      <= 1'b1;
                        transfer_data <= usr_data;
                    end
`endif
                end
                ST_FAIL: begin
                    if (restart) begin
                        cfg_error <= 1'b0;
                        cfg_addr  <= '0;
                        retry_cnt <= '0;
                        cfg_busy  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
module tb_codec_config_sequencer;

    localparam int NREG = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic [7:0]  cfg_addr;
    logic [23:0] cfg_data;
    logic        transfer_start;
    logic [23:0] transfer_data;
    logic        transfer_end = 1'b0;
    logic        transfer_ack_n = 1'b0;
    logic        cfg_busy, cfg_done, cfg_error;
    logic [7:0]  err_index;
`ifdef CODEC_CFG_USER_WRITE_EN
    logic        usr_req = 1'b0;
    logic [23:0] usr_data = 24'h0;
    logic        usr_ack, usr_nack;
`endif

    logic [23:0] tbl [0:NREG-1];
    initial begin
        tbl[0] = 24'h1A0001;
        tbl[1] = 24'h1A0102;
        tbl[2] = 24'h1A0203;
    end

    always_comb begin
        cfg_data = 24'h0;
        if (cfg_addr < 8'(NREG)) cfg_data = tbl[cfg_addr];
    end

    codec_config_sequencer #(
        .NUM_REGS(NREG), .MAX_RETRIES(3), .STARTUP_CYCLES(10),
        .GAP_CYCLES(4), .TIMEOUT_CYCLES(200)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .transfer_start(transfer_start), .transfer_data(transfer_data),
        .transfer_end(transfer_end), .transfer_ack_n(transfer_ack_n),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
        .err_index(err_index)
`ifdef CODEC_CFG_USER_WRITE_EN
        , .usr_req(usr_req), .usr_data(usr_data), .usr_ack(usr_ack), .usr_nack(usr_nack)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural i2c_controller and frame logger
    int          nack_entry = -1;   // table entry that NACKs
    int          nack_limit = 0;    // number of leading attempts of that entry that NACK
    logic        no_end = 1'b0;     // controller never finishes (timeout test)
    logic        log_clr = 1'b0;
    int          xfer_cyc = 0;
    int          att [0:NREG-1];
    logic        cur_nack = 1'b0;
    logic [23:0] flog [0:31];
    int          fcnt = 0;
    int          low_cnt = 0;
    logic        gap_bad = 1'b0;
    int          hi_cnt = 0;
    int          last_hi = 0;

    always @(posedge clk) begin
        if (log_clr) begin
            fcnt    <= 0;
            gap_bad <= 1'b0;
            for (int i = 0; i < NREG; i++) att[i] <= 0;
        end
        if (!transfer_start) begin
            xfer_cyc       <= 0;
            transfer_end   <= 1'b0;
            transfer_ack_n <= 1'b0;
            low_cnt        <= low_cnt + 1;
            if (hi_cnt != 0) last_hi <= hi_cnt;
            hi_cnt         <= 0;
        end else begin
            xfer_cyc <= xfer_cyc + 1;
            hi_cnt   <= hi_cnt + 1;
            if (xfer_cyc == 0) begin
                if (low_cnt < 4) gap_bad <= 1'b1;
                low_cnt <= 0;
                if (!log_clr) begin
                    if (fcnt < 32) flog[fcnt] <= transfer_data;
                    fcnt <= fcnt + 1;
                end
                cur_nack <= 1'b0;
                for (int i = 0; i < NREG; i++) begin
                    if (transfer_data == tbl[i]) begin
                        if (!log_clr) att[i] <= att[i] + 1;
                        if (i == nack_entry && att[i] < nack_limit) cur_nack <= 1'b1;
                    end
                end
            end
            if (xfer_cyc == 5 && !no_end) begin
                transfer_end   <= 1'b1;
                transfer_ack_n <= cur_nack;
            end
        end
    end

    int total = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic pulse_restart();
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
    endtask

    task automatic clear_log();
        @(negedge clk); log_clr = 1'b1;
        @(negedge clk); log_clr = 1'b0;
    endtask

    task automatic wait_finish(input string tag, input int bound);
        int n = 0;
        while (!(cfg_done || cfg_error) && n < bound) begin
            @(negedge clk); n++;
        end
        chk(tag, 32'(cfg_done || cfg_error), 32'd1);
    endtask

    task automatic wait_start(input string tag, input int bound);
        int n = 0;
        while (!transfer_start && n < bound) begin
            @(negedge clk); n++;
        end
        chk(tag, 32'(transfer_start), 32'd1);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(transfer_start), 0);
        chk("rst_busy",  32'(cfg_busy), 1);
        chk("rst_done",  32'(cfg_done), 0);
        chk("rst_error", 32'(cfg_error), 0);
        chk("rst_addr",  32'(cfg_addr), 0);
        chk("rst_eidx",  32'(err_index), 0);
        chk("rst_tdata", 32'(transfer_data), 0);
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
        rst = 1'b0;

        // 1: all ACK
        wait_finish("s1_finish", 2000);
        chk("s1_done",  32'(cfg_done), 1);
        chk("s1_error", 32'(cfg_error), 0);
        chk("s1_busy",  32'(cfg_busy), 0);
        chk("s1_start", 32'(transfer_start), 0);
        chk("s1_fcnt",  32'(fcnt), 3);
        chk("s1_f0",    32'(flog[0]), 32'h1A0001);
        chk("s1_f1",    32'(flog[1]), 32'h1A0102);
        chk("s1_f2",    32'(flog[2]), 32'h1A0203);
        chk("s1_gap",   32'(gap_bad), 0);

        // 2: entry 1 NACKs twice then ACKs
        clear_log();
        nack_entry = 1; nack_limit = 2;
        pulse_restart();
        chk("s2_done_clr", 32'(cfg_done), 0);
        chk("s2_busy",     32'(cfg_busy), 1);
        wait_finish("s2_finish", 3000);
        chk("s2_done",  32'(cfg_done), 1);
        chk("s2_error", 32'(cfg_error), 0);
        chk("s2_fcnt",  32'(fcnt), 5);
        chk("s2_f3",    32'(flog[3]), 32'h1A0102);
        chk("s2_f4",    32'(flog[4]), 32'h1A0203);
        chk("s2_gap",   32'(gap_bad), 0);

        // 3: entry 2 always NACKs
        clear_log();
        nack_entry = 2; nack_limit = 99;
        pulse_restart();
        wait_finish("s3_finish", 3000);
        chk("s3_error", 32'(cfg_error), 1);
        chk("s3_done",  32'(cfg_done), 0);
        chk("s3_eidx",  32'(err_index), 2);
        chk("s3_busy",  32'(cfg_busy), 0);
        chk("s3_fcnt",  32'(fcnt), 6);
        chk("s3_start", 32'(transfer_start), 0);

        // 4: transfer_end never asserted -> timeout retries on entry 0
        clear_log();
        nack_entry = -1; nack_limit = 0; no_end = 1'b1;
        pulse_restart();
        chk("s4_err_clr", 32'(cfg_error), 0);
        wait_finish("s4_finish", 3000);
        chk("s4_error", 32'(cfg_error), 1);
        chk("s4_eidx",  32'(err_index), 0);
        chk("s4_fcnt",  32'(fcnt), 4);
        chk("s4_hilen", 32'(last_hi), 201);

        // 5: restart in FAIL, restart during XFER ignored
        clear_log();
        no_end = 1'b0;
        pulse_restart();
        chk("s5_err_clr", 32'(cfg_error), 0);
        chk("s5_busy",    32'(cfg_busy), 1);
        wait_start("s5_xfer", 50);
        pulse_restart();
        chk("s5_ign_start", 32'(transfer_start), 1);
        chk("s5_ign_addr",  32'(cfg_addr), 0);
        wait_finish("s5_finish", 2000);
        chk("s5_done", 32'(cfg_done), 1);
        chk("s5_fcnt", 32'(fcnt), 3);
        chk("s5_f0",   32'(flog[0]), 32'h1A0001);

        // 6: rst mid-XFER
        pulse_restart();
        wait_start("s6_xfer", 50);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("s6_async_start", 32'(transfer_start), 0);
        chk("s6_rst_busy",    32'(cfg_busy), 1);
        chk("s6_rst_addr",    32'(cfg_addr), 0);
        @(negedge clk); log_clr = 1'b1;
        @(negedge clk); log_clr = 1'b0; rst = 1'b0;
        n = 0;
        while (!transfer_start && n < 100) begin
            @(negedge clk); n++;
        end
        chk("s6_startup_len", 32'(n), 15);
        wait_finish("s6_finish", 2000);
        chk("s6_done", 32'(cfg_done), 1);
        chk("s6_fcnt", 32'(fcnt), 3);
        chk("s6_f0",   32'(flog[0]), 32'h1A0001);

`ifdef CODEC_CFG_USER_WRITE_EN
        // User write from DONE
        @(negedge clk);
        usr_data = 24'h341E00; usr_req = 1'b1;
        @(negedge clk); usr_req = 1'b0;
        n = 0;
        while (!(usr_ack || usr_nack) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("u_ack",  32'(usr_ack), 1);
        chk("u_nack", 32'(usr_nack), 0);
        chk("u_done", 32'(cfg_done), 1);
        chk("u_fcnt", 32'(fcnt), 4);
        chk("u_f3",   32'(flog[3]), 32'h341E00);
        @(negedge clk);
        chk("u_pulse", 32'(usr_ack), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
